// File: rtl/siso_ctrl_pkg.sv
// Shared types and sizing helpers for the SISO loopback sequencer.
// The state encoding is fixed so traces line up with older tooling.
package siso_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Holds 0..WIDTH+DEPTH without wrapping.
    function automatic int cnt_width(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/siso_bit_cnt.sv
// Loadable up-counter with a terminal-count flag at LIMIT-1.
// Load has priority over enable; tc is decoded from the registered count.
module siso_bit_cnt #(
    parameter int W     = 4,
    parameter int LIMIT = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/siso_loop_ctrl.sv
// Sequencer that clears an external SISO chain, shifts a word through it LSB-first
// and captures the returning bits; out_valid rises WIDTH+DEPTH+1 edges after accept.
module siso_loop_ctrl
    import siso_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic             sh_d,
    output logic             sh_clr,
    input  logic             sh_q,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             err,
    output logic             busy
);

    localparam int             CW      = cnt_width(WIDTH, DEPTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] r_sent;
    logic             r_err;
    logic             r_abort_q;

    logic [CW-1:0]    w_cnt;
    logic             w_tc;
    logic             w_rx_en;
    logic [WIDTH-1:0] w_rx_nxt;

    siso_bit_cnt #(
        .W     (CW),
        .LIMIT (WIDTH + DEPTH)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (r_state == ST_CLEAR),
        .i_en   (r_state == ST_SHIFT),
        .o_cnt  (w_cnt),
        .o_tc   (w_tc)
    );

    // The chain output only carries real data once DEPTH bits have gone in.
    assign w_rx_en  = (w_cnt >= DEPTH_C);
    assign w_rx_nxt = {sh_q, r_rx[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_sent    <= '0;
            r_err     <= 1'b0;
            r_abort_q <= 1'b0;
        end else begin
            r_abort_q <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_tx    <= in_data;
                        r_sent  <= in_data;
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        r_abort_q <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        r_abort_q <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tx <= {1'b0, r_tx[WIDTH-1:1]};
                        if (w_rx_en) begin
                            r_rx <= w_rx_nxt;
                        end
                        if (w_tc) begin
                            r_err   <= (w_rx_nxt != r_sent);
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // in_ready also follows rst_n so it drops the moment reset is asserted.
    assign in_ready  = rst_n & (r_state == ST_IDLE);
    assign sh_d      = (r_state == ST_SHIFT) & r_tx[0];
    assign sh_clr    = (r_state == ST_CLEAR) | r_abort_q;
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_rx;
    assign err       = (r_state == ST_DONE) & r_err;
    assign busy      = (r_state != ST_IDLE);

endmodule
